sipo_deserializer: RTL and testbench

- Serial-in/parallel-out receiver: collects C_NUM_BITS serial bits into a word, MSB-first or LSB-first, and presents it through a VLD/RDY holding register.
- Counterpart to the team's universal shift register: that block serializes a parallel word using its shift-left/shift-right modes; this block reassembles the word at the receiving end.
- Double-buffered: the next word can be shifted in while the previous word waits for the consumer.

---
 rtl/sipo_deserializer.sv | 179 +++++++++++++++++
 tb/tb_sipo_deserializer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in/parallel-out receiver with double-buffered VLD/RDY output
// Optional even-parity bit after each word: define SIPO_PARITY_EN.
module sipo_deserializer #(
  parameter int C_NUM_BITS = 24,
  parameter int C_CNT_W    = $clog2(C_NUM_BITS + 1)
) (
  input  logic                  CK,
  input  logic                  RN,
  input  logic                  CLR,
  input  logic                  SEN,
  input  logic                  SDI,
  input  logic                  DIR,
  input  logic                  RDY,
  output logic [C_NUM_BITS-1:0] Q,
  output logic                  VLD,
  output logic                  OVF,
  output logic                  BUSY,
  output logic [C_CNT_W-1:0]    CNT,
  output logic                  PERR
);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_PAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RECV} state_t;
`endif

  localparam logic [C_CNT_W-1:0] LAST_DATA = C_CNT_W'(C_NUM_BITS - 1);

  state_t                state_q, state_d;
  logic [C_NUM_BITS-1:0] sreg_q, sreg_d;
  logic [C_NUM_BITS-1:0] q_q, q_d;
  logic                  vld_q, vld_d;
  logic                  ovf_q, ovf_d;
  logic [C_CNT_W-1:0]    cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic [C_NUM_BITS-1:0] shifted;
  logic [C_NUM_BITS-1:0] word;
  logic                  complete;
`ifdef SIPO_PARITY_EN
  logic                  perr_q, perr_d;
  logic                  par_bad;
`endif

  // dir=1 shifts right (LSB-first), dir=0 shifts left (MSB-first)
  function automatic logic [C_NUM_BITS-1:0] shift_in(
    input logic [C_NUM_BITS-1:0] cur,
    input logic                  lsb_first,
    input logic                  bit_in
  );
    if (lsb_first) shift_in = {bit_in, cur[C_NUM_BITS-1:1]};
    else           shift_in = {cur[C_NUM_BITS-2:0], bit_in};
  endfunction

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    q_d      = q_q;
    vld_d    = vld_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    complete = 1'b0;
    // the first bit of a word uses the live DIR, later bits the latched one
    shifted  = shift_in(sreg_q, (state_q == S_IDLE) ? DIR : dir_q, SDI);
    word     = shifted;
`ifdef SIPO_PARITY_EN
    perr_d   = perr_q;
    par_bad  = 1'b0;
`endif

    if (vld_q && RDY) vld_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (SEN) begin
          dir_d   = DIR;
          sreg_d  = shifted;
          cnt_d   = C_CNT_W'(1);
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (SEN) begin
          if (cnt_q == LAST_DATA) begin
`ifdef SIPO_PARITY_EN
            sreg_d  = shifted;
            cnt_d   = cnt_q + C_CNT_W'(1);
            state_d = S_PAR;
`else
            complete = 1'b1;
            word     = shifted;
`endif
          end else begin
            sreg_d = shifted;
            cnt_d  = cnt_q + C_CNT_W'(1);
          end
        end
      end
`ifdef SIPO_PARITY_EN
      S_PAR: begin
        if (SEN) begin
          complete = 1'b1;
          word     = sreg_q;
          par_bad  = (^sreg_q) ^ SDI;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      // a consumer taking the old word on this edge frees the holding register
      if (!vld_q || RDY) begin
        q_d    = word;
        vld_d  = 1'b1;
`ifdef SIPO_PARITY_EN
        perr_d = par_bad;
`endif
      end else begin
        ovf_d = 1'b1;
      end
      cnt_d   = '0;
      sreg_d  = '0;
      state_d = S_IDLE;
    end

    if (CLR) begin
      state_d = S_IDLE;
      sreg_d  = '0;
      q_d     = '0;
      vld_d   = 1'b0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      dir_d   = 1'b0;
`ifdef SIPO_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      q_q     <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      q_q     <= q_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
`ifdef SIPO_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign Q    = q_q;
  assign VLD  = vld_q;
  assign OVF  = ovf_q;
  assign BUSY = (state_q != S_IDLE);
  assign CNT  = cnt_q;
`ifdef SIPO_PARITY_EN
  assign PERR = perr_q;
`else
  assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - directed-vector bench for sipo_deserializer (C_NUM_BITS=8)
module tb_sipo_deserializer;

  logic       CK, RN, CLR, SEN, SDI, DIR, RDY;
  logic [7:0] Q;
  logic       VLD, OVF, BUSY, PERR;
  logic [3:0] CNT;

  int n_cmp = 0;
  int n_err = 0;

  sipo_deserializer #(.C_NUM_BITS(8)) dut (
    .CK(CK), .RN(RN), .CLR(CLR), .SEN(SEN), .SDI(SDI), .DIR(DIR), .RDY(RDY),
    .Q(Q), .VLD(VLD), .OVF(OVF), .BUSY(BUSY), .CNT(CNT), .PERR(PERR)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic put_bit(input logic b, input logic d);
    SEN = 1'b1;
    SDI = b;
    DIR = d;
    tick();
  endtask

  task automatic idle(input int n);
    SEN = 1'b0;
    repeat (n) tick();
  endtask

  // seq is the transmission order, left to right; DIR flips after the first bit
  task automatic send_seq(input logic [7:0] seq, input logic lsb, input int gap, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      if (gap > 0 && i > 0) idle(gap);
`ifndef SIPO_PARITY_EN
      if (i == 7) RDY = rdy_last;
`endif
      put_bit(seq[7-i], (i == 0) ? lsb : ~lsb);
    end
`ifdef SIPO_PARITY_EN
    if (gap > 0) idle(gap);
    RDY = rdy_last;
    put_bit(^seq, ~lsb);
`endif
  endtask

  initial begin
    logic [7:0] seq;
    RN = 1'b0; CLR = 1'b0; SEN = 1'b0; SDI = 1'b0; DIR = 1'b0; RDY = 1'b0;
    #1;
    check("rst_q", 64'(Q), 64'h0);
    check("rst_vld", 64'(VLD), 64'h0);
    check("rst_ovf", 64'(OVF), 64'h0);
    check("rst_busy", 64'(BUSY), 64'h0);
    check("rst_cnt", 64'(CNT), 64'h0);
    check("rst_perr", 64'(PERR), 64'h0);
    @(negedge CK);
    RN = 1'b1;
    tick();

    // MSB-first, counter walk
    seq = 8'b10100101;
    for (int i = 0; i < 8; i++) begin
      put_bit(seq[7-i], 1'b0);
      if (i < 7) begin
        check("msb_cnt", 64'(CNT), 64'(i + 1));
        check("msb_busy", 64'(BUSY), 64'h1);
        check("msb_vld_early", 64'(VLD), 64'h0);
      end
    end
`ifdef SIPO_PARITY_EN
    check("msb_par_cnt", 64'(CNT), 64'h8);
    check("msb_par_vld_early", 64'(VLD), 64'h0);
    put_bit(1'b0, 1'b0);
`endif
    check("msb_q", 64'(Q), 64'hA5);
    check("msb_vld", 64'(VLD), 64'h1);
    check("msb_cnt_end", 64'(CNT), 64'h0);
    check("msb_busy_end", 64'(BUSY), 64'h0);
    RDY = 1'b1;
    idle(1);
    check("hs_vld", 64'(VLD), 64'h0);
    check("hs_q_hold", 64'(Q), 64'hA5);

    // LSB-first
    send_seq(8'b10100101, 1'b1, 0, 1'b1);
    check("lsb_a5", 64'(Q), 64'hA5);
    check("lsb_a5_vld", 64'(VLD), 64'h1);
    idle(1);
    send_seq(8'b11000000, 1'b1, 0, 1'b1);
    check("lsb_03", 64'(Q), 64'h03);
    check("lsb_perr", 64'(PERR), 64'h0);
    idle(1);

    // gaps between bits
    send_seq(8'hA5, 1'b0, 2, 1'b1);
    check("gap_a5", 64'(Q), 64'hA5);
    check("gap_vld", 64'(VLD), 64'h1);
    idle(1);

    // back-to-back words
    send_seq(8'h3C, 1'b0, 0, 1'b1);
    check("b2b_q1", 64'(Q), 64'h3C);
    check("b2b_vld1", 64'(VLD), 64'h1);
    send_seq(8'hC3, 1'b0, 0, 1'b1);
    check("b2b_q2", 64'(Q), 64'hC3);
    check("b2b_vld2", 64'(VLD), 64'h1);
    check("b2b_ovf", 64'(OVF), 64'h0);
    idle(1);
    check("b2b_drain", 64'(VLD), 64'h0);

    // overflow
    RDY = 1'b0;
    send_seq(8'h11, 1'b0, 0, 1'b0);
    check("ovf_q1", 64'(Q), 64'h11);
    send_seq(8'h22, 1'b0, 0, 1'b0);
    check("ovf_q_kept", 64'(Q), 64'h11);
    check("ovf_flag", 64'(OVF), 64'h1);
    check("ovf_vld", 64'(VLD), 64'h1);
    send_seq(8'h33, 1'b0, 0, 1'b1);
    check("ovf_q3", 64'(Q), 64'h33);
    check("ovf_vld3", 64'(VLD), 64'h1);
    check("ovf_sticky", 64'(OVF), 64'h1);
    RDY = 1'b0;

    // synchronous clear after 4 bits, with CLR beating SEN and RDY
    for (int i = 0; i < 4; i++) put_bit(1'b1, 1'b0);
    check("clr_pre_cnt", 64'(CNT), 64'h4);
    check("clr_pre_busy", 64'(BUSY), 64'h1);
    CLR = 1'b1; RDY = 1'b1; SEN = 1'b1;
    tick();
    CLR = 1'b0; RDY = 1'b0;
    check("clr_cnt", 64'(CNT), 64'h0);
    check("clr_busy", 64'(BUSY), 64'h0);
    check("clr_vld", 64'(VLD), 64'h0);
    check("clr_ovf", 64'(OVF), 64'h0);
    check("clr_q", 64'(Q), 64'h0);
    idle(1);

    // asynchronous reset mid-word
    send_seq(8'h81, 1'b0, 0, 1'b0);
    check("ar_pre_q", 64'(Q), 64'h81);
    for (int i = 0; i < 3; i++) put_bit(1'b1, 1'b0);
    #2 RN = 1'b0;
    #1;
    check("ar_q", 64'(Q), 64'h0);
    check("ar_vld", 64'(VLD), 64'h0);
    check("ar_cnt", 64'(CNT), 64'h0);
    check("ar_busy", 64'(BUSY), 64'h0);
    @(negedge CK);
    RN = 1'b1;
    SEN = 1'b0;
    tick();
    send_seq(8'h7E, 1'b0, 0, 1'b0);
    check("ar_restart_q", 64'(Q), 64'h7E);
    RDY = 1'b1;
    idle(1);

`ifdef SIPO_PARITY_EN
    seq = 8'hA5;
    for (int i = 0; i < 8; i++) put_bit(seq[7-i], 1'b0);
    put_bit(1'b1, 1'b0);
    check("par_bad_q", 64'(Q), 64'hA5);
    check("par_bad_perr", 64'(PERR), 64'h1);
    idle(1);
    for (int i = 0; i < 8; i++) put_bit(seq[7-i], 1'b0);
    put_bit(1'b0, 1'b0);
    check("par_ok_perr", 64'(PERR), 64'h0);
    idle(1);
`else
    check("perr_tied", 64'(PERR), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
